// File: rtl/rr_mux4.sv
// rr_mux4: 4-to-1 registered mux with valid/ready handshakes and round-robin lane arbitration.
// Define RR_MUX4_FIXED_PRIO_EN for fixed priority (lane 0 highest) with no pointer register.
module rr_mux4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [1:0]       out_sel_q,   out_sel_d;
    logic [1:0]       start;
    logic             load;
    logic             found;
    logic [1:0]       grant;
    logic [1:0]       idx;
    logic [WIDTH-1:0] grant_data;

`ifdef RR_MUX4_FIXED_PRIO_EN
    assign start = 2'd0;
`else
    logic [1:0] ptr_q, ptr_d;
    assign start = ptr_q;
`endif

    assign load = !out_valid_q | out_ready;

    // Search from the start lane; the first valid lane wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        found = 1'b0;
        grant = 2'd0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        in_ready = 4'b0000;
        if (load && found && !rst) in_ready[grant] = 1'b1;
    end

    always_comb begin
        case (grant)
            2'd0:    grant_data = in_data0;
            2'd1:    grant_data = in_data1;
            2'd2:    grant_data = in_data2;
            default: grant_data = in_data3;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (load) begin
            out_valid_d = found;
            if (found) begin
                out_data_d = grant_data;
                out_sel_d  = grant;
            end
        end
    end

`ifndef RR_MUX4_FIXED_PRIO_EN
    // Pointer advances only when a beat is actually taken.
    assign ptr_d = (load && found) ? grant + 2'd1 : ptr_q;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
`ifndef RR_MUX4_FIXED_PRIO_EN
            ptr_q       <= 2'd0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
`ifndef RR_MUX4_FIXED_PRIO_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
